fpga_fifo_push_arbiter: RTL

- Packet-atomic round-robin arbiter sharing the write port of one fpga_fifo_v3 among NUM_REQ requesters.
- Each requester offers a valid/ready beat stream delimited by a last flag.
- The arbiter grants one requester at a time and holds the grant until that requester's last beat is pushed, so packets never interleave in the FIFO.
- It sits directly in front of fpga_fifo_v3 and drives its push_i/data_i/flush_i.

---
 rtl/fpga_fifo_push_arbiter_if.sv | 26 ++
 rtl/fpga_fifo_push_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fpga_fifo_push_arbiter_if.sv
// Shared write-port bundle between the requesters, the push arbiter and fpga_fifo_v3.
// The master side drives requests and FIFO status; the slave side is the arbiter.

interface fpga_fifo_push_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_push;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_flush;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_data, fifo_flush
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_push, fifo_data, fifo_flush
    );
endinterface

// File: rtl/fpga_fifo_push_arbiter.sv
// Packet-atomic round-robin arbiter for the write port of one fpga_fifo_v3.
// A grant is held from a packet's first beat until its last beat (or the watchdog) is pushed.

module fpga_fifo_push_arbiter #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  MAX_BEATS  = 64,
    localparam int unsigned IdxW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    fpga_fifo_push_arbiter_if.slave bus,
    output logic                    grant_valid_o,
    output logic [IdxW-1:0]         grant_idx_o,
    output logic                    timeout_o
);
    localparam int unsigned     CntW    = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_BEATS);
    localparam logic [CntW-1:0] CntLast = (MAX_BEATS > 0) ? CntW'(MAX_BEATS - 1) : '0;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]    grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic               timeout_q, timeout_d;
    logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;

    logic               any_valid;
    logic [IdxW-1:0]    winner;
    logic [NUM_REQ-1:0] owner_sel;
    logic               owner_valid, owner_last;
    logic               xfer, wd_fire;
    logic [IdxW-1:0]    next_ptr;

    // Descending scan leaves the lowest set index at or above rr_ptr in hi_idx and the
    // lowest set index overall in lo_idx; the latter is the wrap-around winner.
    always_comb begin
        logic            hi_found;
        logic [IdxW-1:0] hi_idx, lo_idx;
        hi_found  = 1'b0;
        any_valid = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                any_valid = 1'b1;
                lo_idx    = IdxW'(k);
                if (IdxW'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxW'(k);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        owner_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_sel[k] = (grant_idx_q == IdxW'(k));
        end
    end

    assign owner_valid = |(owner_sel & bus.req_valid);
    assign owner_last  = |(owner_sel & bus.req_last);

    always_comb begin
        bus.req_ready = '0;
        bus.fifo_push = 1'b0;
        bus.fifo_data = '0;
        if (state_q == StLocked) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner_sel[k]) begin
                    bus.fifo_data = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (!flush_i && !bus.fifo_full) begin
                bus.req_ready = owner_sel;
                bus.fifo_push = owner_valid;
            end
        end
    end

    // Gated so that nothing reaches the FIFO while the arbiter is held in reset.
    assign bus.fifo_flush = flush_i & rst_ni;

    assign xfer     = bus.fifo_push;
    assign wd_fire  = (MAX_BEATS > 0) && xfer && !owner_last && (beat_cnt_q == CntLast);
    assign next_ptr = (grant_idx_q == IdxLast) ? '0 : grant_idx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        beat_cnt_d    = beat_cnt_q;
        timeout_d     = 1'b0;
        if (flush_i) begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
            beat_cnt_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_d       = StLocked;
                        grant_idx_d   = winner;
                        grant_valid_d = 1'b1;
                        beat_cnt_d    = '0;
                    end
                end
                StLocked: begin
                    if (xfer) begin
                        if (beat_cnt_q != CntMax) begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                        if (owner_last || wd_fire) begin
                            state_d       = StIdle;
                            grant_valid_d = 1'b0;
                            beat_cnt_d    = '0;
                            rr_ptr_d      = next_ptr;
                            timeout_d     = wd_fire;
                        end
                    end
                end
                default: begin
                    state_d       = StIdle;
                    grant_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign grant_idx_o   = grant_idx_q;
    assign timeout_o     = timeout_q;

endmodule
